// File: rtl/rect_motion_ctl.sv
// rect_motion_ctl: once-per-frame position scheduler for the on-screen rectangle.
// In IDLE it follows the mouse. A left click drops it under gravity, with damped
// bounces off the floor, until it comes to rest. All updates happen on the rising
// edge of vblnk, so the picture never tears mid-frame.
// Optional build macro RECT_CLAMP_EN: IDLE tracking clamps the rectangle so that
// it stays fully on screen.
module rect_motion_ctl #(
    parameter int GRAVITY      = 1,
    parameter int MAX_VEL      = 32,
    parameter int BOUNCE_SHIFT = 1,
    parameter int MIN_VEL      = 2,
    parameter int FLOOR_Y      = 704
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblnk,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        busy,
    output logic [1:0]  state
);

    // Screen and rectangle geometry (1024x768 mode, 48x64 rectangle).
    localparam int HOR_PIXELS  = 1024;
    localparam int RECT_LENGTH = 48;

    localparam logic [11:0] X_MAX = 12'(HOR_PIXELS - RECT_LENGTH);
    localparam logic [11:0] FLOOR = 12'(FLOOR_Y);
    localparam logic [7:0]  GRAV8 = 8'(GRAVITY);
    localparam logic [7:0]  MAXV8 = 8'(MAX_VEL);
    localparam logic [7:0]  MINV8 = 8'(MIN_VEL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        RISE = 2'd2,
        REST = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [11:0] xpos_reg, xpos_next;
    logic [11:0] ypos_reg, ypos_next;
    logic [7:0]  vel_reg, vel_next;
    logic        click_pend_reg, click_pend_next;
    logic        vblnk_q, left_q;

    logic        tick;
    logic        press;
    logic        click;
    logic [12:0] y_sum;
    logic [8:0]  vel_sum;
    logic [7:0]  vb;

    // Frame tick and button press are single-cycle rising-edge pulses.
    assign tick  = vblnk & ~vblnk_q;
    assign press = mouse_left & ~left_q;
    // A press on the tick cycle itself counts as a click for that tick.
    assign click = click_pend_reg | press;

    // State and motion registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            xpos_reg       <= 12'd0;
            ypos_reg       <= 12'd0;
            vel_reg        <= 8'd0;
            click_pend_reg <= 1'b0;
            vblnk_q        <= 1'b0;
            left_q         <= 1'b0;
        end else begin
            state_reg      <= state_next;
            xpos_reg       <= xpos_next;
            ypos_reg       <= ypos_next;
            vel_reg        <= vel_next;
            click_pend_reg <= click_pend_next;
            vblnk_q        <= vblnk;
            left_q         <= mouse_left;
        end
    end

    // Next-state and motion arithmetic, evaluated only on a frame tick.
    always_comb begin
        state_next      = state_reg;
        xpos_next       = xpos_reg;
        ypos_next       = ypos_reg;
        vel_next        = vel_reg;
        click_pend_next = click_pend_reg;

        // 13-bit sum so a position near 4095 cannot wrap past the floor test.
        y_sum   = {1'b0, ypos_reg} + {5'd0, vel_reg};
        vel_sum = {1'b0, vel_reg} + {1'b0, GRAV8};
        vb      = vel_reg - (vel_reg >> BOUNCE_SHIFT);

        if (press) begin
            click_pend_next = 1'b1;
        end

        if (tick) begin
            // Any pending click is consumed by this tick, whether used or not.
            click_pend_next = 1'b0;
            case (state_reg)
                IDLE: begin
                    if (click) begin
                        state_next = FALL;
                        vel_next   = 8'd0;
                    end else begin
`ifdef RECT_CLAMP_EN
                        xpos_next = (mouse_xpos > X_MAX) ? X_MAX : mouse_xpos;
                        ypos_next = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;
`else
                        xpos_next = mouse_xpos;
                        ypos_next = mouse_ypos;
`endif
                    end
                end
                FALL: begin
                    if (y_sum >= {1'b0, FLOOR}) begin
                        ypos_next = FLOOR;
                        if (vb < MINV8) begin
                            state_next = REST;
                            vel_next   = 8'd0;
                        end else begin
                            state_next = RISE;
                            vel_next   = vb;
                        end
                    end else begin
                        ypos_next = y_sum[11:0];
                        vel_next  = (vel_sum > {1'b0, MAXV8}) ? MAXV8 : vel_sum[7:0];
                    end
                end
                RISE: begin
                    if ({4'd0, vel_reg} >= ypos_reg) begin
                        // Would pass the top of the screen: stop at the ceiling.
                        state_next = FALL;
                        ypos_next  = 12'd0;
                        vel_next   = 8'd0;
                    end else if (vel_reg <= GRAV8) begin
                        // Apex of the bounce.
                        state_next = FALL;
                        ypos_next  = ypos_reg - {4'd0, vel_reg};
                        vel_next   = 8'd0;
                    end else begin
                        ypos_next = ypos_reg - {4'd0, vel_reg};
                        vel_next  = vel_reg - GRAV8;
                    end
                end
                REST: begin
                    if (click) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign xpos  = xpos_reg;
    assign ypos  = ypos_reg;
    assign state = state_reg;
    assign busy  = (state_reg == FALL) || (state_reg == RISE);

endmodule

// File: tb/tb_rect_motion_ctl.sv
// tb_rect_motion_ctl: directed test of the rectangle motion scheduler with
// hand-computed position and state sequences.
module tb_rect_motion_ctl;

    logic        clk;
    logic        rst_n;
    logic        vblnk;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        busy;
    logic [1:0]  state;

    int checks_cnt = 0;
    int errors_cnt = 0;

    rect_motion_ctl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vblnk      (vblnk),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .xpos       (xpos),
        .ypos       (ypos),
        .busy       (busy),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // One-cycle vblnk pulse; optionally a press on the same cycle.
    // Returns at a negedge, well after the updating posedge.
    task automatic frame(input logic with_click);
        @(negedge clk);
        vblnk      = 1'b1;
        mouse_left = with_click;
        @(negedge clk);
        vblnk      = 1'b0;
        mouse_left = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press_btn();
        @(negedge clk);
        mouse_left = 1'b1;
        @(negedge clk);
        mouse_left = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Bounce sequence after a drop from y=634 reaches ypos=700 with vel=12.
    int exp_y[26] = '{704, 698, 693, 689, 686, 684, 683,
                      683, 684, 686, 689, 693, 698, 704,
                      701, 699, 698,
                      698, 699, 701, 704,
                      702, 701,
                      701, 702, 704};
    int exp_s[26] = '{2, 2, 2, 2, 2, 2, 1,
                      1, 1, 1, 1, 1, 1, 2,
                      2, 2, 1,
                      1, 1, 1, 2,
                      2, 1,
                      1, 1, 3};

    initial begin
        rst_n      = 1'b0;
        vblnk      = 1'b0;
        mouse_xpos = 12'd0;
        mouse_ypos = 12'd0;
        mouse_left = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_xpos", int'(xpos), 0);
        check("rst_ypos", int'(ypos), 0);
        check("rst_state", int'(state), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Mouse tracking in IDLE; nothing moves without a tick.
        mouse_xpos = 12'd100;
        mouse_ypos = 12'd200;
        repeat (3) @(negedge clk);
        check("no_tick_x", int'(xpos), 0);
        frame(1'b0);
        check("idle_x", int'(xpos), 100);
        check("idle_y", int'(ypos), 200);
        check("idle_busy", int'(busy), 0);

        // Drop from 600 with gravity 1.
        mouse_xpos = 12'd300;
        mouse_ypos = 12'd600;
        frame(1'b0);
        press_btn();
        check("pend_hold_state", int'(state), 0);
        frame(1'b0);
        check("drop_state", int'(state), 1);
        check("drop_busy", int'(busy), 1);
        check("drop_y", int'(ypos), 600);
        mouse_xpos = 12'd50;
        frame(1'b0);
        check("fall_y0", int'(ypos), 600);
        frame(1'b0);
        check("fall_y1", int'(ypos), 601);
        frame(1'b0);
        check("fall_y2", int'(ypos), 603);
        frame(1'b0);
        check("fall_y3", int'(ypos), 606);
        check("fall_x_held", int'(xpos), 300);

        // Velocity saturation at 32: drop from y=0.
        do_reset();
        mouse_xpos = 12'd10;
        mouse_ypos = 12'd0;
        frame(1'b0);
        frame(1'b1);
        check("sat_state", int'(state), 1);
        repeat (32) frame(1'b0);
        check("sat_y32", int'(ypos), 496);
        frame(1'b0);
        check("sat_y33", int'(ypos), 528);
        frame(1'b0);
        check("sat_y34", int'(ypos), 560);
        frame(1'b0);
        check("sat_y35", int'(ypos), 592);

        // Bounce sequence: drop from 634 reaches 700 with vel 12.
        do_reset();
        mouse_xpos = 12'd20;
        mouse_ypos = 12'd634;
        frame(1'b0);
        frame(1'b1);
        repeat (12) frame(1'b0);
        check("bnc_y700", int'(ypos), 700);
        check("bnc_state_fall", int'(state), 1);
        for (int i = 0; i < 26; i++) begin
            // A click during motion must be ignored.
            if (i == 22) press_btn();
            frame(1'b0);
            check($sformatf("bnc_y[%0d]", i), int'(ypos), exp_y[i]);
            check($sformatf("bnc_s[%0d]", i), int'(state), exp_s[i]);
        end
        check("rest_busy", int'(busy), 0);
        frame(1'b0);
        check("rest_hold_state", int'(state), 3);
        check("rest_hold_y", int'(ypos), 704);
        mouse_xpos = 12'd400;
        mouse_ypos = 12'd300;
        frame(1'b1);
        check("rest_click_state", int'(state), 0);
        check("rest_click_x", int'(xpos), 20);
        check("rest_click_y", int'(ypos), 704);
        frame(1'b0);
        check("resume_x", int'(xpos), 400);
        check("resume_y", int'(ypos), 300);

        // Short drop from 702: 702, 703, then floor with vb=1 -> REST.
        mouse_xpos = 12'd40;
        mouse_ypos = 12'd702;
        frame(1'b0);
        frame(1'b1);
        frame(1'b0);
        check("short_y0", int'(ypos), 702);
        frame(1'b0);
        check("short_y1", int'(ypos), 703);
        frame(1'b0);
        check("short_y2", int'(ypos), 704);
        check("short_state", int'(state), 3);
        check("short_busy", int'(busy), 0);
        frame(1'b1);
        check("short_idle", int'(state), 0);

        // Off-screen mouse coordinates.
        mouse_xpos = 12'd1020;
        mouse_ypos = 12'd760;
        frame(1'b0);
`ifdef RECT_CLAMP_EN
        check("clamp_x", int'(xpos), 976);
        check("clamp_y", int'(ypos), 704);
`else
        check("raw_x", int'(xpos), 1020);
        check("raw_y", int'(ypos), 760);
`endif

        // Reset mid-RISE with a click pending.
        mouse_xpos = 12'd5;
        mouse_ypos = 12'd600;
        frame(1'b0);
        frame(1'b1);
        repeat (15) frame(1'b0);
        check("mid_rise_state", int'(state), 2);
        check("mid_rise_y", int'(ypos), 704);
        press_btn();
        do_reset();
        check("rst2_xpos", int'(xpos), 0);
        check("rst2_ypos", int'(ypos), 0);
        check("rst2_state", int'(state), 0);
        check("rst2_busy", int'(busy), 0);
        mouse_xpos = 12'd77;
        mouse_ypos = 12'd88;
        frame(1'b0);
        check("rst2_no_pend_state", int'(state), 0);
        check("rst2_track_x", int'(xpos), 77);
        check("rst2_track_y", int'(ypos), 88);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
